// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// sram_fifo_ctrl: 1024x32 streaming FIFO built on a two-port SRAM macro.
// A 2-entry output buffer hides the macro's registered read latency.
module sram_fifo_ctrl #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RSTB,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   level,
    output logic          empty,
    output logic [AW-1:0] A1,
    output logic          CSB1,
    output logic          OEB1,
    input  logic [DW-1:0] O1,
    output logic [AW-1:0] A2,
    output logic          CSB2,
    output logic          WEB2,
    output logic [DW-1:0] I2
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   mem_cnt;
    logic          inflight;
    logic [1:0]    obuf_cnt;
    logic [DW-1:0] obuf0, obuf1;

    logic          push, pop, rd_iss;
    logic [2:0]    occ;

    // Gating push with RSTB keeps the write port idle while reset is held.
    assign in_ready  = (mem_cnt != FULL_CNT);
    assign push      = in_valid & in_ready & ~flush & RSTB;
    assign out_valid = (obuf_cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign occ       = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
    assign rd_iss    = (mem_cnt != '0) & (occ < 3'd2) & ~flush;

    assign A1   = rptr;
    assign CSB1 = ~rd_iss;
    assign OEB1 = 1'b0;
    assign A2   = wptr;
    assign CSB2 = ~push;
    assign WEB2 = ~push;
    assign I2   = in_data;

    assign out_data = obuf0;
    assign level    = mem_cnt + (AW+1)'(inflight) + (AW+1)'(obuf_cnt);
    assign empty    = (level == '0);

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            obuf_cnt <= 2'd0;
            obuf0    <= '0;
            obuf1    <= '0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
            obuf_cnt <= 2'd0;
            obuf0    <= '0;
            obuf1    <= '0;
        end else begin
            if (push)
                wptr <= (wptr == LAST_ADR) ? '0 : wptr + AW'(1);
            if (rd_iss)
                rptr <= (rptr == LAST_ADR) ? '0 : rptr + AW'(1);
            case ({push, rd_iss})
                2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
                2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
                default: mem_cnt <= mem_cnt;
            endcase
            inflight <= rd_iss;
            obuf_cnt <= obuf_cnt + 2'(inflight) - 2'(pop);
            // O1 is only meaningful in the cycle after an issue (inflight).
            case (obuf_cnt)
                2'd0: begin
                    if (inflight) obuf0 <= O1;
                end
                2'd1: begin
                    if (inflight && pop) obuf0 <= O1;
                    else if (inflight)   obuf1 <= O1;
                end
                default: begin
                    if (pop) begin
                        obuf0 <= obuf1;
                        if (inflight) obuf1 <= O1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// Directed testbench for sram_fifo_ctrl with a behavioural SRAM_32x1024_2P model.
module tb_sram_fifo_ctrl;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 32;

    logic          CLK = 1'b0;
    logic          RSTB = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, empty, CSB1, OEB1, CSB2, WEB2;
    logic [DW-1:0] out_data, I2;
    logic [DW-1:0] O1;
    logic [AW:0]   level;
    logic [AW-1:0] A1, A2;

    logic [DW-1:0] sram [0:DEPTH-1];
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;
    logic [AW:0]   exp_lvl;
    int n_checks = 0;
    int n_fail   = 0;

    sram_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RSTB(RSTB), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .empty(empty),
        .A1(A1), .CSB1(CSB1), .OEB1(OEB1), .O1(O1),
        .A2(A2), .CSB2(CSB2), .WEB2(WEB2), .I2(I2)
    );

    always #5 CLK = ~CLK;

    // Macro model: write captured on the edge, read data registered one cycle.
    always @(posedge CLK) begin
        if (!CSB2 && !WEB2) sram[A2] <= I2;
        if (!CSB1) O1 <= sram[A1];
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RSTB = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5_A5A5; out_ready = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++; if (CSB1 !== 1'b1) begin n_fail++; $display("FAIL rst_csb1 got=%b exp=1", CSB1); end
        n_checks++; if (CSB2 !== 1'b1) begin n_fail++; $display("FAIL rst_csb2 got=%b exp=1", CSB2); end
        n_checks++; if (WEB2 !== 1'b1) begin n_fail++; $display("FAIL rst_web2 got=%b exp=1", WEB2); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        n_checks++; if (level !== 11'd0) begin n_fail++; $display("FAIL rst_level got=%0d exp=0", level); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got=%b exp=1", empty); end
        n_checks++; if (A1 !== 10'd0 || A2 !== 10'd0) begin n_fail++; $display("FAIL rst_addr got A1=%0d A2=%0d exp=0", A1, A2); end
        n_checks++; if (OEB1 !== 1'b0) begin n_fail++; $display("FAIL rst_oeb1 got=%b exp=0", OEB1); end
        in_valid = 1'b0; out_ready = 1'b0;
        RSTB = 1'b1;
        tick();
        @(negedge CLK);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rel_empty got=%b exp=1", empty); end
        tick();
    endtask

    task automatic test_single;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        @(negedge CLK);
        n_checks++; if (CSB2 !== 1'b0 || WEB2 !== 1'b0) begin n_fail++; $display("FAIL single_wr_en got CSB2=%b WEB2=%b exp=0/0", CSB2, WEB2); end
        n_checks++; if (A2 !== 10'd0) begin n_fail++; $display("FAIL single_a2 got=%0d exp=0", A2); end
        n_checks++; if (I2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_i2 got=%h exp=deadbeef", I2); end
        tick(); in_valid = 1'b0;
        @(negedge CLK);
        n_checks++; if (CSB1 !== 1'b0 || A1 !== 10'd0) begin n_fail++; $display("FAIL single_issue got CSB1=%b A1=%0d exp=0/0", CSB1, A1); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_c1_valid got=%b exp=0", out_valid); end
        tick();
        @(negedge CLK);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_c2_valid got=%b exp=0", out_valid); end
        n_checks++; if (level !== 11'd1) begin n_fail++; $display("FAIL single_c2_level got=%0d exp=1", level); end
        tick();
        @(negedge CLK);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_c3_valid got=%b exp=1", out_valid); end
        n_checks++; if (out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_c3_data got=%h exp=deadbeef", out_data); end
        tick();
        @(negedge CLK);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_c4_empty got=%b exp=1", empty); end
        tick();
    endtask

    task automatic test_fill;
        int idx;
        int popped;
        idx = 0; popped = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            in_valid = (idx < 1028);
            in_data  = 32'(idx);
            @(negedge CLK);
            if (in_valid && in_ready) begin q.push_back(in_data); idx++; end
            tick();
        end
        in_valid = 1'b0;
        @(negedge CLK);
        n_checks++; if (idx != 1026) begin n_fail++; $display("FAIL fill_accepted got=%0d exp=1026", idx); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (level !== 11'd1026) begin n_fail++; $display("FAIL fill_level got=%0d exp=1026", level); end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 1200 && q.size() > 0; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                n_checks++; if (in_ready !== 1'b0 || CSB1 !== 1'b0) begin n_fail++; $display("FAIL drain_first got in_ready=%b CSB1=%b exp=0/0", in_ready, CSB1); end
            end
            if (c == 1) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_rise got=%b exp=1", in_ready); end
            end
            if (out_valid) begin
                exp_d = q.pop_front(); popped++;
                n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL drain_data got=%h exp=%h", out_data, exp_d); end
            end
            tick();
        end
        @(negedge CLK);
        n_checks++; if (popped != 1026) begin n_fail++; $display("FAIL drain_count got=%0d exp=1026", popped); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", empty); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_stream;
        int sent;
        sent = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            in_data = 32'h1000_0000 + 32'(sent);
            @(negedge CLK);
            if (c >= 3) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_bubble cycle=%0d got=%b exp=1", c, out_valid); end
                n_checks++; if (level !== 11'd3) begin n_fail++; $display("FAIL stream_level cycle=%0d got=%0d exp=3", c, level); end
            end
            if (in_valid && in_ready) begin q.push_back(in_data); sent++; end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin n_fail++; $display("FAIL stream_underflow got=%h exp=none", out_data); end
                else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin n_fail++; $display("FAIL stream_data got=%h exp=%h", out_data, exp_d); end
                end
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (sent != 3000) begin n_fail++; $display("FAIL stream_sent got=%0d exp=3000", sent); end
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            @(negedge CLK);
            if (out_valid) begin
                exp_d = q.pop_front();
                n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL stream_tail got=%h exp=%h", out_data, exp_d); end
            end
            tick();
        end
        @(negedge CLK);
        n_checks++; if (empty !== 1'b1 || q.size() != 0) begin n_fail++; $display("FAIL stream_empty got=%b left=%0d exp=1/0", empty, q.size()); end
        tick();
    endtask

    task automatic test_random;
        int memcnt;
        memcnt = 0;
        for (int c = 0; c < 20000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            @(negedge CLK);
            exp_lvl = 11'(q.size());
            n_checks++; if (level !== exp_lvl) begin n_fail++; $display("FAIL rand_level cycle=%0d got=%0d exp=%0d", c, level, exp_lvl); end
            n_checks++; if (!CSB2 && memcnt == DEPTH) begin n_fail++; $display("FAIL rand_full_write cycle=%0d got CSB2=0 exp=1", c); end
            if (in_valid && in_ready) q.push_back(in_data);
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin n_fail++; $display("FAIL rand_underflow got=%h exp=none", out_data); end
                else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) begin n_fail++; $display("FAIL rand_data got=%h exp=%h", out_data, exp_d); end
                end
            end
            memcnt = memcnt + (CSB2 ? 0 : 1) - (CSB1 ? 0 : 1);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 1200 && q.size() > 0; c++) begin
            @(negedge CLK);
            if (out_valid) begin
                exp_d = q.pop_front();
                n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL rand_drain got=%h exp=%h", out_data, exp_d); end
            end
            tick();
        end
        @(negedge CLK);
        n_checks++; if (empty !== 1'b1 || q.size() != 0) begin n_fail++; $display("FAIL rand_empty got=%b left=%0d exp=1/0", empty, q.size()); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush(input bit use_reset);
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 32'hF000_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        out_ready = 1'b1;
        @(negedge CLK);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hF000_0000) begin n_fail++; $display("FAIL flush_pre_pop got v=%b d=%h exp=1/f0000000", out_valid, out_data); end
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hBAD0_BAD0;
        if (!use_reset) flush = 1'b1;
        @(negedge CLK);
        n_checks++; if (level !== 11'd5) begin n_fail++; $display("FAIL flush_pre_level rst=%0b got=%0d exp=5", use_reset, level); end
        if (!use_reset) begin
            n_checks++; if (CSB2 !== 1'b1 || CSB1 !== 1'b1) begin n_fail++; $display("FAIL flush_gate got CSB1=%b CSB2=%b exp=1/1", CSB1, CSB2); end
            tick();
            flush = 1'b0; in_valid = 1'b0;
            @(negedge CLK);
        end else begin
            #2 RSTB = 1'b0;
            @(negedge CLK);
            n_checks++; if (CSB2 !== 1'b1) begin n_fail++; $display("FAIL rstpulse_csb2 got=%b exp=1", CSB2); end
            RSTB = 1'b1; in_valid = 1'b0;
        end
        n_checks++; if (level !== 11'd0) begin n_fail++; $display("FAIL flush_level rst=%0b got=%0d exp=0", use_reset, level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid rst=%0b got=%b exp=0", use_reset, out_valid); end
        tick();
        in_valid = 1'b1; in_data = 32'h0000_1234; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge CLK);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale rst=%0b cycle=%0d got=%b exp=0", use_reset, c, out_valid); end
            tick();
        end
        @(negedge CLK);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_1234) begin n_fail++; $display("FAIL flush_next rst=%0b got v=%b d=%h exp=1/00001234", use_reset, out_valid, out_data); end
        tick();
        @(negedge CLK);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_after_empty rst=%0b got=%b exp=1", use_reset, empty); end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_flush(1'b0);
        test_flush(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
